// File: rtl/pipe_types_pkg.sv
// Shared types for the elastic pipeline stage: occupancy state encoding and the
// default bubble payload (sll $0,$0,0 encodes as all zeros).
package pipe_types_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam logic [31:0] PIPE_NOP = 32'h0000_0000;

    localparam int PERF_NUM_CNT = 3;
    localparam int PERF_STALL   = 0;
    localparam int PERF_FLUSH   = 1;
    localparam int PERF_XFER    = 2;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: +1 per cycle with inc high, sticks at all-ones,
// cleared only by the asynchronous reset.
module pipe_sat_counter #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    output logic [CNTW-1:0] cnt
);

    logic [CNTW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != {CNTW{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register with a 2-entry skid buffer (main + skid) so
// in_ready only depends on registered state and flush. Define PIPE_STAGE_PERF_EN
// to add saturating stall/flush/transfer counters.
module pipe_stage_elastic
    import pipe_types_pkg::*;
#(
    parameter int           W         = 32,
    parameter logic [W-1:0] NOP_VALUE = W'(PIPE_NOP),
    parameter int           CNTW      = 16
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt,
    output logic [CNTW-1:0] xfer_cnt
`endif
);

    pipe_state_t    state_reg;
    logic [W-1:0]   main_reg;
    logic [W-1:0]   skid_reg;
    logic           out_valid_reg;
    logic           in_fire;
    logic           out_fire;

    assign in_ready  = (state_reg != FULL) && !flush;
    assign out_valid = out_valid_reg;
    assign out_data  = main_reg;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_reg && out_ready;

    // out_valid_reg mirrors (state_reg != EMPTY) but is kept as its own flop
    // so the downstream valid comes straight off a register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg     <= EMPTY;
            main_reg      <= NOP_VALUE;
            skid_reg      <= NOP_VALUE;
            out_valid_reg <= 1'b0;
        end else if (flush) begin
            state_reg     <= EMPTY;
            main_reg      <= NOP_VALUE;
            skid_reg      <= NOP_VALUE;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        state_reg     <= BUSY;
                        main_reg      <= in_data;
                        out_valid_reg <= 1'b1;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_reg <= in_data;
                    end else if (in_fire) begin
                        state_reg <= FULL;
                        skid_reg  <= in_data;
                    end else if (out_fire) begin
                        state_reg     <= EMPTY;
                        main_reg      <= NOP_VALUE;
                        out_valid_reg <= 1'b0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain path can move.
                    if (out_fire) begin
                        state_reg <= BUSY;
                        main_reg  <= skid_reg;
                        skid_reg  <= NOP_VALUE;
                    end
                end
                default: begin
                    state_reg     <= EMPTY;
                    main_reg      <= NOP_VALUE;
                    skid_reg      <= NOP_VALUE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [PERF_NUM_CNT-1:0] perf_inc;
    logic [CNTW-1:0]         perf_cnt [PERF_NUM_CNT];

    assign perf_inc[PERF_STALL] = out_valid_reg && !out_ready;
    assign perf_inc[PERF_FLUSH] = flush;
    assign perf_inc[PERF_XFER]  = out_fire;

    genvar gi;
    generate
        for (gi = 0; gi < PERF_NUM_CNT; gi = gi + 1) begin : g_perf
            pipe_sat_counter #(
                .CNTW (CNTW)
            ) u_cnt (
                .clk   (CLK),
                .rst_n (nRST),
                .inc   (perf_inc[gi]),
                .cnt   (perf_cnt[gi])
            );
        end
    endgenerate

    assign stall_cnt = perf_cnt[PERF_STALL];
    assign flush_cnt = perf_cnt[PERF_FLUSH];
    assign xfer_cnt  = perf_cnt[PERF_XFER];
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: table of per-cycle handshake vectors
// plus hand-written reset, concurrent-fire and (with PIPE_STAGE_PERF_EN) counter sequences.
module tb_pipe_stage_elastic;

    localparam int W    = 32;
    localparam int CNTW = 4;

    logic            CLK;
    logic            nRST;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_data;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] flush_cnt;
    logic [CNTW-1:0] xfer_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    pipe_stage_elastic #(
        .W    (W),
        .CNTW (CNTW)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
        .xfer_cnt  (xfer_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic         flush;
        logic         in_valid;
        logic [W-1:0] in_data;
        logic         out_ready;
        logic         exp_in_ready;   // before the edge
        logic         exp_out_valid;  // after the edge
        logic [W-1:0] exp_out_data;   // after the edge
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic f, input logic iv, input logic [W-1:0] d, input logic ordy);
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        #3;
        nRST = 1'b1;
        tick();
    endtask

    initial begin
        // flush, in_valid, in_data, out_ready, exp_in_ready, exp_out_valid, exp_out_data
        vecs[0]  = '{1'b0, 1'b1, 32'h1, 1'b1, 1'b1, 1'b1, 32'h1};
        vecs[1]  = '{1'b0, 1'b1, 32'h2, 1'b1, 1'b1, 1'b1, 32'h2};
        vecs[2]  = '{1'b0, 1'b1, 32'h3, 1'b1, 1'b1, 1'b1, 32'h3};
        vecs[3]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 32'hA, 1'b0, 1'b1, 1'b1, 32'hA};
        vecs[5]  = '{1'b0, 1'b1, 32'hB, 1'b0, 1'b1, 1'b1, 32'hA};
        vecs[6]  = '{1'b0, 1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 32'hA};
        vecs[7]  = '{1'b0, 1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 32'hB};
        vecs[8]  = '{1'b0, 1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 32'hC};
        vecs[9]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 32'h5, 1'b0, 1'b1, 1'b1, 32'h5};
        vecs[11] = '{1'b0, 1'b1, 32'h6, 1'b0, 1'b1, 1'b1, 32'h5};
        vecs[12] = '{1'b1, 1'b1, 32'hD, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[14] = '{1'b0, 1'b1, 32'h7, 1'b0, 1'b1, 1'b1, 32'h7};
        vecs[15] = '{1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[16] = '{1'b1, 1'b1, 32'h9, 1'b0, 1'b0, 1'b0, 32'h0};

        drive(1'b0, 1'b0, '0, 1'b0);
        nRST = 1'b0;
        #12;
        check("reset_out_valid", W'(out_valid), W'(1'b0));
        check("reset_in_ready",  W'(in_ready),  W'(1'b1));
        check("reset_out_data",  out_data,      32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        tick();

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].flush, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
            #1;
            check($sformatf("vec%0d_in_ready", i), W'(in_ready), W'(vecs[i].exp_in_ready));
            tick();
            check($sformatf("vec%0d_out_valid", i), W'(out_valid), W'(vecs[i].exp_out_valid));
            check($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_out_data);
            $display("vec%0d flush=%0d iv=%0d d=0x%0h ordy=%0d -> ov=%0d od=0x%0h", i,
                     vecs[i].flush, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready,
                     out_valid, out_data);
        end

        // Asynchronous reset mid-stream, asserted away from any clock edge.
        drive(1'b0, 1'b1, 32'h55, 1'b0);
        tick();
        drive(1'b0, 1'b1, 32'h66, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        #2;
        nRST = 1'b0;
        #1;
        check("midreset_out_valid", W'(out_valid), W'(1'b0));
        check("midreset_in_ready",  W'(in_ready),  W'(1'b1));
        check("midreset_out_data",  out_data,      32'h0);
        $display("midstream reset -> ov=%0d ir=%0d od=0x%0h", out_valid, in_ready, out_data);
        #2;
        nRST = 1'b1;
        tick();

        // Concurrent in_fire/out_fire in BUSY: each word emerges one cycle after accept.
        drive(1'b0, 1'b1, 32'h100, 1'b1);
        tick();
        for (int i = 1; i <= 10; i++) begin
            drive(1'b0, 1'b1, 32'h100 + i, 1'b1);
            #1;
            check($sformatf("busy%0d_in_ready", i), W'(in_ready), W'(1'b1));
            check($sformatf("busy%0d_out_data_pre", i), out_data, 32'h100 + i - 1);
            tick();
            check($sformatf("busy%0d_out_valid", i), W'(out_valid), W'(1'b1));
            check($sformatf("busy%0d_out_data", i), out_data, 32'h100 + i);
            $display("busy%0d accept=0x%0h out=0x%0h", i, 32'h100 + i, out_data);
        end
        drive(1'b0, 1'b0, '0, 1'b1);
        tick();
        check("busy_drain_out_valid", W'(out_valid), W'(1'b0));

`ifdef PIPE_STAGE_PERF_EN
        drive(1'b0, 1'b0, '0, 1'b0);
        do_reset();
        check("perf_reset_stall", W'(stall_cnt), W'(0));
        drive(1'b0, 1'b1, 32'h1, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, '0, 1'b0);
            tick();
        end
        for (int i = 2; i <= 4; i++) begin
            drive(1'b0, 1'b1, W'(i), 1'b1);
            tick();
        end
        drive(1'b0, 1'b0, '0, 1'b1);
        tick();
        drive(1'b1, 1'b0, '0, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        check("perf_stall_3", W'(stall_cnt), W'(3));
        check("perf_flush_1", W'(flush_cnt), W'(1));
        check("perf_xfer_4",  W'(xfer_cnt),  W'(4));
        $display("perf stall=%0d flush=%0d xfer=%0d", stall_cnt, flush_cnt, xfer_cnt);
        drive(1'b0, 1'b1, 32'h5, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        check("perf_stall_sat", W'(stall_cnt), W'(15));
        check("perf_flush_hold", W'(flush_cnt), W'(1));
        check("perf_xfer_hold",  W'(xfer_cnt),  W'(4));
        $display("perf after 20 stalls stall=%0d flush=%0d xfer=%0d", stall_cnt, flush_cnt, xfer_cnt);
`else
        do_reset();
        check("post_reset_out_valid", W'(out_valid), W'(1'b0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
